// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: prefix FSM, modifier/lock tracking, and an
// event FIFO for the CPU. Keyboard response bytes go to a polled register.
module ps2_scancode_decoder #(
    parameter int pFifoDepth = 16,
    parameter int pAw        = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           sc_valid_i,
    input  logic [7:0]     sc_dat_i,
    input  logic           sc_perr_i,
    input  logic           ev_rd_i,
    output logic [15:0]    ev_dat_o,
    output logic           ev_empty_o,
    output logic [pAw:0]   ev_count_o,
    output logic           irq_o,
    output logic [7:0]     mod_o,
    output logic [7:0]     resp_o,
    output logic           resp_vld_o,
    input  logic           resp_clr_i,
    input  logic           err_clr_i,
    output logic           ovf_o,
    output logic           perr_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_PAUSE
    } state_t;

    localparam logic [pAw:0] DepthC = (pAw+1)'(pFifoDepth);

    state_t         state_q, state_d;
    logic [2:0]     skip_q, skip_d;
    logic [7:0]     mod_q, mod_d;
    logic           caps_held_q, caps_held_d;
    logic           num_held_q, num_held_d;

    logic           key_vld;
    logic           key_brk;
    logic           key_ext;
    logic [7:0]     key_code;
    logic           is_resp;
    logic           fake_shift;

    logic           ev_vld_p0;
    logic [15:0]    ev_word_p0;

    logic [15:0]    mem [pFifoDepth];
    logic [pAw-1:0] wr_q, rd_q;
    logic [pAw:0]   count_q;
    logic           full;
    logic           pop;
    logic           push_ok;

    logic [7:0]     resp_q;
    logic           resp_vld_q;
    logic           ovf_q;
    logic           perr_q;

    function automatic logic is_resp_byte(input logic [7:0] b);
        return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
    endfunction

    // Byte classification: prefix tracking and key-event candidate
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        key_vld  = 1'b0;
        key_brk  = 1'b0;
        key_ext  = 1'b0;
        key_code = sc_dat_i;
        is_resp  = 1'b0;
        if (sc_valid_i) begin
            if (sc_perr_i) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sc_dat_i == 8'hE0) begin
                            state_d = ST_EXT;
                        end else if (sc_dat_i == 8'hF0) begin
                            state_d = ST_BRK;
                        end else if (sc_dat_i == 8'hE1) begin
                            state_d = ST_PAUSE;
                            skip_d  = 3'd7;
                        end else if (is_resp_byte(sc_dat_i)) begin
                            is_resp = 1'b1;
                        end else begin
                            key_vld = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (sc_dat_i == 8'hF0) begin
                            state_d = ST_EXTBRK;
                        end else begin
                            key_vld = 1'b1;
                            key_ext = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        key_vld = 1'b1;
                        key_brk = 1'b1;
                        state_d = ST_IDLE;
                    end
                    ST_EXTBRK: begin
                        key_vld = 1'b1;
                        key_brk = 1'b1;
                        key_ext = 1'b1;
                        state_d = ST_IDLE;
                    end
                    ST_PAUSE: begin
                        skip_d = skip_q - 3'd1;
                        if (skip_q <= 3'd1) begin
                            key_vld  = 1'b1;
                            key_code = 8'hE1;
                            state_d  = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Modifier/lock update; the event word carries the post-update state
    always_comb begin
        mod_d       = mod_q;
        caps_held_d = caps_held_q;
        num_held_d  = num_held_q;
        fake_shift  = 1'b0;
        if (key_vld) begin
            if (key_ext) begin
                case (key_code)
                    8'h12, 8'h59: fake_shift = 1'b1;
                    8'h14:        mod_d[3] = ~key_brk;
                    8'h11:        mod_d[5] = ~key_brk;
                    default:      ;
                endcase
            end else begin
                case (key_code)
                    8'h12: mod_d[0] = ~key_brk;
                    8'h59: mod_d[1] = ~key_brk;
                    8'h14: mod_d[2] = ~key_brk;
                    8'h11: mod_d[4] = ~key_brk;
                    8'h58: begin
                        if (key_brk) begin
                            caps_held_d = 1'b0;
                        end else begin
                            if (!caps_held_q) mod_d[6] = ~mod_q[6];
                            caps_held_d = 1'b1;
                        end
                    end
                    8'h77: begin
                        if (key_brk) begin
                            num_held_d = 1'b0;
                        end else begin
                            if (!num_held_q) mod_d[7] = ~mod_q[7];
                            num_held_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        ev_vld_p0  = key_vld & ~fake_shift;
        ev_word_p0 = {key_brk, key_ext, mod_d[0] | mod_d[1], mod_d[2] | mod_d[3],
                      mod_d[4] | mod_d[5], mod_d[6], mod_d[7], 1'b0, key_code};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            skip_q      <= 3'd0;
            mod_q       <= 8'h00;
            caps_held_q <= 1'b0;
            num_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            mod_q       <= mod_d;
            caps_held_q <= caps_held_d;
            num_held_q  <= num_held_d;
        end
    end

    // FIFO: a pop frees the slot a same-cycle push needs when full
    assign full    = (count_q == DepthC);
    assign pop     = ev_rd_i & (count_q != '0);
    assign push_ok = ev_vld_p0 & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_q] <= ev_word_p0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + pAw'(1);
            if (pop)     rd_q <= rd_q + pAw'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (pAw+1)'(1);
                2'b01:   count_q <= count_q - (pAw+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_q     <= 8'h00;
            resp_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            if (is_resp) begin
                resp_q     <= sc_dat_i;
                resp_vld_q <= 1'b1;
            end else if (resp_clr_i) begin
                resp_vld_q <= 1'b0;
            end
            if (ev_vld_p0 && full && !pop) ovf_q <= 1'b1;
            else if (err_clr_i)            ovf_q <= 1'b0;
            if (sc_valid_i && sc_perr_i)   perr_q <= 1'b1;
            else if (err_clr_i)            perr_q <= 1'b0;
        end
    end

    assign ev_empty_o = (count_q == '0);
    assign ev_dat_o   = ev_empty_o ? 16'h0000 : mem[rd_q];
    assign ev_count_o = count_q;
    assign irq_o      = ~ev_empty_o;
    assign mod_o      = mod_q;
    assign resp_o     = resp_q;
    assign resp_vld_o = resp_vld_q;
    assign ovf_o      = ovf_q;
    assign perr_o     = perr_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with an expected-event queue.
module tb_ps2_scancode_decoder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sc_valid_i = 1'b0;
    logic [7:0]  sc_dat_i = 8'h00;
    logic        sc_perr_i = 1'b0;
    logic        ev_rd_i = 1'b0;
    logic [15:0] ev_dat_o;
    logic        ev_empty_o;
    logic [4:0]  ev_count_o;
    logic        irq_o;
    logic [7:0]  mod_o;
    logic [7:0]  resp_o;
    logic        resp_vld_o;
    logic        resp_clr_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic        ovf_o;
    logic        perr_o;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    ps2_scancode_decoder #(.pFifoDepth(16), .pAw(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sc_valid_i(sc_valid_i), .sc_dat_i(sc_dat_i),
        .sc_perr_i(sc_perr_i), .ev_rd_i(ev_rd_i), .ev_dat_o(ev_dat_o),
        .ev_empty_o(ev_empty_o), .ev_count_o(ev_count_o), .irq_o(irq_o), .mod_o(mod_o),
        .resp_o(resp_o), .resp_vld_o(resp_vld_o), .resp_clr_i(resp_clr_i),
        .err_clr_i(err_clr_i), .ovf_o(ovf_o), .perr_o(perr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic pe);
        sc_valid_i = 1'b1;
        sc_dat_i   = b;
        sc_perr_i  = pe;
        @(posedge clk_i);
        #1;
        sc_valid_i = 1'b0;
        sc_perr_i  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (!ev_empty_o && guard < 64) begin
            check({tag, "_sb_has_entry"}, 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) check({tag, "_ev"}, ev_dat_o, exp_q.pop_front());
            ev_rd_i = 1'b1;
            @(posedge clk_i);
            #1;
            ev_rd_i = 1'b0;
            guard++;
        end
        check({tag, "_drain_bound"}, 16'(guard < 64), 16'd1);
        check({tag, "_sb_left"}, 16'(exp_q.size()), 16'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"}, 16'(ev_empty_o), 16'd1);
        check({tag, "_count"}, 16'(ev_count_o), 16'd0);
        check({tag, "_irq"},   16'(irq_o), 16'd0);
        check({tag, "_dat"},   ev_dat_o, 16'h0000);
        check({tag, "_mod"},   16'(mod_o), 16'h00);
        check({tag, "_resp"},  16'(resp_o), 16'h00);
        check({tag, "_rvld"},  16'(resp_vld_o), 16'd0);
        check({tag, "_ovf"},   16'(ovf_o), 16'd0);
        check({tag, "_perr"},  16'(perr_o), 16'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_vals("rst");
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Make/break
        exp_q.push_back(16'h001C); send(8'h1C, 1'b0);
        check("lat_empty", 16'(ev_empty_o), 16'd0);
        check("lat_irq", 16'(irq_o), 16'd1);
        check("lat_dat", ev_dat_o, 16'h001C);
        send(8'hF0, 1'b0);
        exp_q.push_back(16'h801C); send(8'h1C, 1'b0);
        check("mb_count", 16'(ev_count_o), 16'd2);
        drain("mb");
        check("mb_mod", 16'(mod_o), 16'h00);

        // Extended break, fake shift
        send(8'hE0, 1'b0); send(8'hF0, 1'b0);
        exp_q.push_back(16'hC075); send(8'h75, 1'b0);
        send(8'hE0, 1'b0); send(8'h12, 1'b0);
        check("fs_count", 16'(ev_count_o), 16'd1);
        drain("fs");
        check("fs_mod", 16'(mod_o), 16'h00);

        // Shift and caps lock with typematic repeat
        exp_q.push_back(16'h2012); send(8'h12, 1'b0);
        check("sh_mod", 16'(mod_o), 16'h01);
        exp_q.push_back(16'h201C); send(8'h1C, 1'b0);
        exp_q.push_back(16'h2458); send(8'h58, 1'b0);
        exp_q.push_back(16'h2458); send(8'h58, 1'b0);
        send(8'hF0, 1'b0);
        exp_q.push_back(16'hA458); send(8'h58, 1'b0);
        exp_q.push_back(16'h241C); send(8'h1C, 1'b0);
        drain("caps");
        check("caps_mod", 16'(mod_o), 16'h41);
        send(8'hF0, 1'b0);
        exp_q.push_back(16'h8412); send(8'h12, 1'b0);
        drain("shrel");
        check("shrel_mod", 16'(mod_o), 16'h40);

        // Responses
        send(8'hFA, 1'b0);
        check("resp_val", 16'(resp_o), 16'h00FA);
        check("resp_vld", 16'(resp_vld_o), 16'd1);
        check("resp_noev", 16'(ev_empty_o), 16'd1);
        resp_clr_i = 1'b1; @(posedge clk_i); #1; resp_clr_i = 1'b0;
        check("resp_clr", 16'(resp_vld_o), 16'd0);
        resp_clr_i = 1'b1; send(8'hFE, 1'b0); resp_clr_i = 1'b0;
        check("resp_win_vld", 16'(resp_vld_o), 16'd1);
        check("resp_win_val", 16'(resp_o), 16'h00FE);

        // Parity error abandons prefix
        send(8'hE0, 1'b0);
        send(8'h1C, 1'b1);
        check("perr_set", 16'(perr_o), 16'd1);
        check("perr_noev", 16'(ev_empty_o), 16'd1);
        exp_q.push_back(16'h041C); send(8'h1C, 1'b0);
        drain("perr");
        err_clr_i = 1'b1; send(8'h33, 1'b1); err_clr_i = 1'b0;
        check("perr_win", 16'(perr_o), 16'd1);
        err_clr_i = 1'b1; @(posedge clk_i); #1; err_clr_i = 1'b0;
        check("perr_clr", 16'(perr_o), 16'd0);

        // Overflow
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(16'h041C);
            send(8'h1C, 1'b0);
        end
        check("ovf_count", 16'(ev_count_o), 16'd16);
        check("ovf_flag", 16'(ovf_o), 16'd1);
        check("ovf_rdpush_head", ev_dat_o, exp_q.pop_front());
        exp_q.push_back(16'h041D);
        ev_rd_i = 1'b1; send(8'h1D, 1'b0); ev_rd_i = 1'b0;
        check("ovf_rdpush_count", 16'(ev_count_o), 16'd16);
        err_clr_i = 1'b1; @(posedge clk_i); #1; err_clr_i = 1'b0;
        check("ovf_clr", 16'(ovf_o), 16'd0);
        drain("ovf");

        // Pause sequence
        send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
        send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0);
        check("pause_pending", 16'(ev_empty_o), 16'd1);
        exp_q.push_back(16'h04E1); send(8'h77, 1'b0);
        drain("pause");
        check("pause_mod", 16'(mod_o), 16'h40);

        // Reset mid-sequence
        send(8'h1C, 1'b1);
        send(8'h1C, 1'b0);
        send(8'hE0, 1'b0);
        rst_ni = 1'b0;
        #2;
        check_reset_vals("midrst");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        exp_q.push_back(16'h001C); send(8'h1C, 1'b0);
        drain("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
